pipelined_barrel_shift_unit: RTL and testbench

//   Pipelined, multi-mode successor to the combinational barrel rotator.

---
 rtl/barrel_shift_pkg.sv | 28 ++
 rtl/barrel_shift_stage.sv | 52 +++++
 rtl/pipelined_barrel_shift_unit.sv | 133 +++++++++++++
 tb/tb_pipelined_barrel_shift_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shift_pkg.sv
// Shared mode/direction encodings and elaboration-time helpers for the
// pipelined barrel shift unit.
package barrel_shift_pkg;

    typedef enum logic [1:0] {
        MODE_ROT = 2'b00,
        MODE_LSH = 2'b01,
        MODE_ASH = 2'b10,
        MODE_RSV = 2'b11
    } shift_mode_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Rotate distance of log level k, folded into the word so that levels whose
    // nominal distance exceeds a non-power-of-2 width still compose to amount mod N.
    function automatic int stage_rot_amt(input int k, input int n);
        return (1 << k) % n;
    endfunction

    function automatic bit slice_after(input int k, input int shift_width, input int pipe_stages);
        for (int j = 0; j < pipe_stages; j++) begin
            if (((j + 1) * shift_width) / pipe_stages - 1 == k) return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One combinational log level: moves the word by 2^STAGE_IDX (rotate distance
// folded mod DATA_WIDTH) when en is set; mode 11 always passes through.
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGE_IDX  = 0
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  en,
    input  logic                  dir,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int SHIFT = 1 << STAGE_IDX;
    localparam int ROT   = stage_rot_amt(STAGE_IDX, DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    logic fill;

    // Arithmetic right shifts keep the MSB, so the sign survives every level.
    assign fill = data_in[DATA_WIDTH-1];

    always_comb begin
        data_out = data_in;
        if (en) begin
            case (mode)
                MODE_ROT: begin
                    if (dir == DIR_LEFT)
                        data_out = (data_in << ROT) | (data_in >> (DATA_WIDTH - ROT));
                    else
                        data_out = (data_in >> ROT) | (data_in << (DATA_WIDTH - ROT));
                end
                MODE_LSH: begin
                    if (dir == DIR_LEFT)
                        data_out = data_in << SHIFT;
                    else
                        data_out = data_in >> SHIFT;
                end
                MODE_ASH: begin
                    if (dir == DIR_LEFT)
                        data_out = data_in << SHIFT;
                    else
                        data_out = (data_in >> SHIFT) | (fill ? ~(ONES >> SHIFT) : '0);
                end
                default: data_out = data_in;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shift_unit.sv
// Pipelined rotate/logical/arithmetic shifter: SHIFT_WIDTH log levels with
// PIPE_STAGES register slices sharing one global advance enable.
module pipelined_barrel_shift_unit
    import barrel_shift_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
    parameter int PIPE_STAGES = 2,
    parameter int USER_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [SHIFT_WIDTH-1:0] in_amount,
    input  logic                   in_dir,
    input  logic [1:0]             in_mode,
    input  logic [USER_WIDTH-1:0]  in_user,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [USER_WIDTH-1:0]  out_user,
    output logic                   out_err
);

    logic adv;

    // Index k holds the beat entering log level k; index SHIFT_WIDTH is the output.
    logic [DATA_WIDTH-1:0]  s_data   [SHIFT_WIDTH+1];
    logic [SHIFT_WIDTH-1:0] s_amount [SHIFT_WIDTH+1];
    logic [1:0]             s_mode   [SHIFT_WIDTH+1];
    logic [USER_WIDTH-1:0]  s_user   [SHIFT_WIDTH+1];
    logic                   s_dir    [SHIFT_WIDTH+1];
    logic                   s_sign   [SHIFT_WIDTH+1];
    logic                   s_valid  [SHIFT_WIDTH+1];
    logic                   unused_tail;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign s_data[0]   = in_data;
    assign s_amount[0] = in_amount;
    assign s_mode[0]   = in_mode;
    assign s_user[0]   = in_user;
    assign s_dir[0]    = in_dir;
    assign s_sign[0]   = in_data[DATA_WIDTH-1];
    assign s_valid[0]  = in_valid;

    for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_level
        localparam bit IS_SLICE = slice_after(k, SHIFT_WIDTH, PIPE_STAGES);
        localparam bit IS_LAST  = (k == SHIFT_WIDTH - 1);

        logic [DATA_WIDTH-1:0] shifted;
        logic [DATA_WIDTH-1:0] level_data;

        barrel_shift_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .STAGE_IDX  (k)
        ) u_stage (
            .data_in  (s_data[k]),
            .en       (s_amount[k][k]),
            .dir      (s_dir[k]),
            .mode     (s_mode[k]),
            .data_out (shifted)
        );

        // Amounts >= DATA_WIDTH (only reachable for non-power-of-2 widths) saturate.
        always_comb begin
            level_data = shifted;
            if (IS_LAST && (int'(s_amount[k]) >= DATA_WIDTH)) begin
                if (s_mode[k] == MODE_LSH)
                    level_data = '0;
                else if (s_mode[k] == MODE_ASH)
                    level_data = (s_dir[k] == DIR_LEFT) ? '0 : {DATA_WIDTH{s_sign[k]}};
            end
        end

        if (IS_SLICE) begin : g_slice
            logic [DATA_WIDTH-1:0]  data_q;
            logic [SHIFT_WIDTH-1:0] amount_q;
            logic [1:0]             mode_q;
            logic [USER_WIDTH-1:0]  user_q;
            logic                   dir_q;
            logic                   sign_q;
            logic                   valid_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_q   <= '0;
                    amount_q <= '0;
                    mode_q   <= MODE_ROT;
                    user_q   <= '0;
                    dir_q    <= DIR_RIGHT;
                    sign_q   <= 1'b0;
                    valid_q  <= 1'b0;
                end else if (adv) begin
                    data_q   <= level_data;
                    amount_q <= s_amount[k];
                    mode_q   <= s_mode[k];
                    user_q   <= s_user[k];
                    dir_q    <= s_dir[k];
                    sign_q   <= s_sign[k];
                    valid_q  <= s_valid[k];
                end
            end

            assign s_data[k+1]   = data_q;
            assign s_amount[k+1] = amount_q;
            assign s_mode[k+1]   = mode_q;
            assign s_user[k+1]   = user_q;
            assign s_dir[k+1]    = dir_q;
            assign s_sign[k+1]   = sign_q;
            assign s_valid[k+1]  = valid_q;
        end else begin : g_pass
            assign s_data[k+1]   = level_data;
            assign s_amount[k+1] = s_amount[k];
            assign s_mode[k+1]   = s_mode[k];
            assign s_user[k+1]   = s_user[k];
            assign s_dir[k+1]    = s_dir[k];
            assign s_sign[k+1]   = s_sign[k];
            assign s_valid[k+1]  = s_valid[k];
        end
    end

    assign out_valid = s_valid[SHIFT_WIDTH];
    assign out_data  = s_data[SHIFT_WIDTH];
    assign out_user  = s_user[SHIFT_WIDTH];
    assign out_err   = out_valid && (s_mode[SHIFT_WIDTH] == MODE_RSV);

    assign unused_tail = ^{s_amount[SHIFT_WIDTH], s_dir[SHIFT_WIDTH], s_sign[SHIFT_WIDTH]};

endmodule

// File: tb/tb_pipelined_barrel_shift_unit.sv
// Bench for pipelined_barrel_shift_unit: a 32-bit/2-slice unit and a 12-bit/3-slice
// unit share stimulus; sel picks which one is driven and observed.
module tb_pipelined_barrel_shift_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        in_valid, out_ready, in_dir;
    logic [1:0]  in_mode;
    logic [31:0] in_data;
    logic [4:0]  in_amount;
    logic [3:0]  in_user;

    logic        a_in_ready, a_out_valid, a_out_err;
    logic [31:0] a_out_data;
    logic [3:0]  a_out_user;
    logic        b_in_ready, b_out_valid, b_out_err;
    logic [11:0] b_out_data;
    logic [3:0]  b_out_user;

    logic        o_valid, i_ready, o_err;
    logic [31:0] o_data;
    logic [3:0]  o_user;

    int n_tests = 0;
    int n_fail  = 0;

    pipelined_barrel_shift_unit #(
        .DATA_WIDTH(32), .SHIFT_WIDTH(5), .PIPE_STAGES(2), .USER_WIDTH(4)
    ) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && !sel), .in_ready(a_in_ready),
        .in_data(in_data), .in_amount(in_amount), .in_dir(in_dir),
        .in_mode(in_mode), .in_user(in_user),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_user(a_out_user), .out_err(a_out_err)
    );

    pipelined_barrel_shift_unit #(
        .DATA_WIDTH(12), .SHIFT_WIDTH(4), .PIPE_STAGES(3), .USER_WIDTH(4)
    ) dut12 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && sel), .in_ready(b_in_ready),
        .in_data(in_data[11:0]), .in_amount(in_amount[3:0]), .in_dir(in_dir),
        .in_mode(in_mode), .in_user(in_user),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_user(b_out_user), .out_err(b_out_err)
    );

    always_comb begin
        o_valid = sel ? b_out_valid : a_out_valid;
        i_ready = sel ? b_in_ready  : a_in_ready;
        o_err   = sel ? b_out_err   : a_out_err;
        o_data  = sel ? {20'd0, b_out_data} : a_out_data;
        o_user  = sel ? b_out_user  : a_out_user;
    end

    // Reference: result bit i takes source bit i+amt (right) or i-amt (left);
    // rotate wraps the source index mod n, shifts fill out-of-range sources.
    function automatic logic [31:0] model(input logic [31:0] d_in, input int amt,
                                          input bit left, input logic [1:0] mode, input int n);
        logic [31:0] d, r;
        int src;
        bit sgn, b;
        d   = (n == 32) ? d_in : (d_in & ((32'd1 << n) - 32'd1));
        sgn = ((d >> (n - 1)) & 32'd1) != 0;
        r   = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (mode == 2'b11 || amt == 0) src = i;
            else if (mode == 2'b00) src = left ? ((i - (amt % n)) + n) % n : (i + amt) % n;
            else src = left ? i - amt : i + amt;
            if (src >= 0 && src < n) b = ((d >> src) & 32'd1) != 0;
            else b = (mode == 2'b10 && !left) ? sgn : 1'b0;
            if (b) r = r | (32'd1 << i);
        end
        return r;
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; in_amount = '0; in_dir = 1'b0;
        in_mode = 2'b00; in_user = '0; out_ready = 1'b1;
    endtask

    // Sends one beat with out_ready=1 and reports what emerges and how many cycles it took.
    task automatic send_one(input logic [31:0] d, input int a, input bit dr, input logic [1:0] m,
                            input logic [3:0] u, output logic [31:0] rd, output logic [3:0] ru,
                            output logic re, output int lat);
        int guard = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_amount = a[4:0]; in_dir = dr; in_mode = m;
        in_user = u; out_ready = 1'b1;
        #1;
        while (!i_ready && guard < 20) begin @(posedge clk); #2; guard++; end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = $urandom; in_amount = 5'($urandom); in_mode = 2'($urandom);
        in_user = 4'($urandom); in_dir = 1'($urandom);
        lat = 1;
        while (!o_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = o_data; ru = o_user; re = o_err;
    endtask

    task automatic test_reset();
        idle_inputs();
        sel = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({a_out_valid, a_out_data, a_out_user, a_out_err} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_out32: valid=%0b data=%h user=%h err=%0b, required all zero",
                     a_out_valid, a_out_data, a_out_user, a_out_err);
        end
        n_tests++;
        if ({b_out_valid, b_out_data, b_out_user, b_out_err} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_out12: valid=%0b data=%h user=%h err=%0b, required all zero",
                     b_out_valid, b_out_data, b_out_user, b_out_err);
        end
        n_tests++;
        if ({a_in_ready, b_in_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 11", {a_in_ready, b_in_ready});
        end
    endtask

    task automatic test_rotate();
        logic [31:0] rd; logic [3:0] ru; logic re; int lat;
        sel = 1'b0;
        send_one(32'h8000_0001, 4, 1'b0, 2'b00, 4'd5, rd, ru, re, lat);
        n_tests++;
        if (lat !== 2 || rd !== 32'h1800_0000 || ru !== 4'd5) begin
            n_fail++;
            $display("FAIL rot_right4: lat=%0d data=%h user=%0d, required lat=2 data=18000000 user=5",
                     lat, rd, ru);
        end
        send_one(32'h8000_0001, 4, 1'b1, 2'b00, 4'd9, rd, ru, re, lat);
        n_tests++;
        if (lat !== 2 || rd !== 32'h0000_0018 || ru !== 4'd9) begin
            n_fail++;
            $display("FAIL rot_left4: lat=%0d data=%h user=%0d, required lat=2 data=00000018 user=9",
                     lat, rd, ru);
        end
    endtask

    task automatic test_shifts();
        logic [31:0] rd; logic [3:0] ru; logic re; int lat;
        sel = 1'b0;
        send_one(32'hF000_000F, 4, 1'b0, 2'b01, 4'd1, rd, ru, re, lat);
        n_tests++;
        if (rd !== 32'h0F00_0000) begin
            n_fail++; $display("FAIL lsr4: got %h, required 0f000000", rd);
        end
        send_one(32'hF000_000F, 4, 1'b0, 2'b10, 4'd2, rd, ru, re, lat);
        n_tests++;
        if (rd !== 32'hFF00_0000) begin
            n_fail++; $display("FAIL asr4: got %h, required ff000000", rd);
        end
        send_one(32'hF000_000F, 31, 1'b1, 2'b01, 4'd3, rd, ru, re, lat);
        n_tests++;
        if (rd !== 32'h8000_0000) begin
            n_fail++; $display("FAIL lsl31: got %h, required 80000000", rd);
        end
        send_one(32'hC3A5_0F96, 0, 1'b0, 2'b10, 4'd4, rd, ru, re, lat);
        n_tests++;
        if (rd !== 32'hC3A5_0F96) begin
            n_fail++; $display("FAIL asr0: got %h, required c3a50f96", rd);
        end
    endtask

    task automatic test_non_pow2();
        logic [31:0] rd; logic [3:0] ru; logic re; int lat;
        sel = 1'b1;
        send_one(32'h0000_0ABC, 13, 1'b0, 2'b00, 4'd7, rd, ru, re, lat);
        n_tests++;
        if (lat !== 3 || rd !== 32'h0000_055E || ru !== 4'd7) begin
            n_fail++;
            $display("FAIL n12_rot_right13: lat=%0d data=%h user=%0d, required lat=3 data=55e user=7",
                     lat, rd, ru);
        end
        send_one(32'h0000_0ABC, 13, 1'b0, 2'b01, 4'd0, rd, ru, re, lat);
        n_tests++;
        if (rd !== 32'h0000_0000) begin
            n_fail++; $display("FAIL n12_lsr13: got %h, required 000", rd);
        end
        send_one(32'h0000_0ABC, 15, 1'b0, 2'b10, 4'd0, rd, ru, re, lat);
        n_tests++;
        if (rd !== 32'h0000_0FFF) begin
            n_fail++; $display("FAIL n12_asr15: got %h, required fff", rd);
        end
        sel = 1'b0;
    endtask

    task automatic test_mode11();
        logic [31:0] rd; logic [3:0] ru; logic re; int lat;
        sel = 1'b0;
        send_one(32'h1234_5678, 7, 1'b1, 2'b11, 4'd6, rd, ru, re, lat);
        n_tests++;
        if (rd !== 32'h1234_5678 || re !== 1'b1) begin
            n_fail++; $display("FAIL mode11: data=%h err=%0b, required 12345678 err=1", rd, re);
        end
        send_one(32'h1234_5678, 8, 1'b0, 2'b00, 4'd6, rd, ru, re, lat);
        n_tests++;
        if (rd !== 32'h7812_3456 || re !== 1'b0) begin
            n_fail++; $display("FAIL mode11_next: data=%h err=%0b, required 78123456 err=0", rd, re);
        end
    endtask

    // pattern=1: out_ready cycles 1,0,0,1 with in_valid held; pattern=0: random both sides.
    task automatic test_stream(input bit use12, input int nbeats, input bit pattern);
        logic [31:0] exp_d[$];
        logic [3:0]  exp_u[$];
        logic        exp_e[$];
        logic [31:0] nd, held_d, ed;
        logic [3:0]  nu, held_u;
        logic [1:0]  nm;
        logic        ndir, stalled;
        int na, n, sent, got, cyc;
        sel = use12;
        n = use12 ? 12 : 32;
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held_d = '0; held_u = '0;
        nd = $urandom; na = $urandom_range(0, use12 ? 15 : 31); nm = 2'($urandom);
        ndir = 1'($urandom); nu = 4'($urandom);
        @(posedge clk); #1;
        while (got < nbeats && cyc < 3000) begin
            out_ready = pattern ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
            in_valid  = (sent < nbeats) && (pattern || $urandom_range(0, 3) != 0);
            in_data = nd; in_amount = na[4:0]; in_mode = nm; in_dir = ndir; in_user = nu;
            #1;
            if (stalled) begin
                n_tests++;
                if ({o_valid, o_data, o_user} !== {1'b1, held_d, held_u}) begin
                    n_fail++;
                    $display("FAIL stall_stable: valid=%0b data=%h user=%h, required 1 %h %h",
                             o_valid, o_data, o_user, held_d, held_u);
                end
            end
            if (!i_ready) begin
                n_tests++;
                if ((o_valid && !out_ready) !== 1'b1) begin
                    n_fail++;
                    $display("FAIL in_ready_low: out_valid=%0b out_ready=%0b, required full and stalled",
                             o_valid, out_ready);
                end
            end
            if (o_valid && out_ready) begin
                n_tests++;
                if (exp_d.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got data=%h with no beat outstanding", o_data);
                end else begin
                    ed = exp_d.pop_front();
                    if ({o_data, o_user, o_err} !== {ed, exp_u[0], exp_e[0]}) begin
                        n_fail++;
                        $display("FAIL stream_data: got %h/%h/%0b, required %h/%h/%0b",
                                 o_data, o_user, o_err, ed, exp_u[0], exp_e[0]);
                    end
                    void'(exp_u.pop_front());
                    void'(exp_e.pop_front());
                end
                got++;
            end
            if (in_valid && i_ready) begin
                exp_d.push_back(model(nd, na, ndir, nm, n));
                exp_u.push_back(nu);
                exp_e.push_back(nm == 2'b11);
                sent++;
                nd = $urandom; na = $urandom_range(0, use12 ? 15 : 31); nm = 2'($urandom);
                ndir = 1'($urandom); nu = 4'($urandom);
            end
            stalled = o_valid && !out_ready;
            held_d = o_data; held_u = o_user;
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
        n_tests++;
        if (got !== nbeats || exp_d.size() != 0 || sent !== nbeats) begin
            n_fail++;
            $display("FAIL stream_count: sent=%0d received=%0d left=%0d, required %0d each and 0 left",
                     sent, got, exp_d.size(), nbeats);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        sel = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h0000_0123; in_amount = 5'd3; in_mode = 2'b00; in_user = 4'd1;
        @(posedge clk); #1;
        in_data = 32'h0000_0456; in_amount = 5'd5; in_user = 4'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL inflight_pre: out_valid=%0b, required 0", o_valid);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            if (o_valid) seen++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL reset_inflight: %0d beats emerged, required 0", seen);
        end
        idle_inputs();
        sel = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_rotate();
        test_shifts();
        test_non_pow2();
        test_mode11();
        test_stream(1'b0, 8, 1'b1);
        test_stream(1'b1, 8, 1'b1);
        test_stream(1'b0, 300, 1'b0);
        test_stream(1'b1, 300, 1'b0);
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
